// File: rtl/hash_table_pkg.sv
// Shared hash-table types: RAM data word, table address width and the read-tag record.
// Used by data_table_rd_arbiter (optional statistics build macro: DATA_TABLE_RD_ARB_STATS_EN).
package hash_table;

  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int DATA_WIDTH       = 32;
  localparam int MAX_SEARCH_ENG   = 16;
  localparam int MAX_ENG_W        = $clog2(MAX_SEARCH_ENG);

  typedef logic [DATA_WIDTH-1:0] ram_data_t;

  // Sized for the largest engine count so one tag format serves every instance.
  typedef logic [MAX_ENG_W-1:0] eng_idx_t;

  typedef struct packed {
    logic     valid;
    eng_idx_t engIdx;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: scans req starting at ptr (wrapping at
// REQ_CNT) and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter  int REQ_CNT = 4,
  localparam int IDX_W   = $clog2(REQ_CNT)
) (
  input  logic [REQ_CNT-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [REQ_CNT-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  localparam logic [IDX_W:0] REQ_CNT_W = (IDX_W+1)'(REQ_CNT);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Wrap is done against REQ_CNT explicitly so non-power-of-two counts never visit
  // indices that do not exist.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      w_sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (w_sum >= REQ_CNT_W) begin
        w_sum = w_sum - REQ_CNT_W;
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/data_table_rd_arbiter.sv
// Shares one data-table RAM read port among ENG_CNT search engines, round-robin, and
// routes each read's data-valid back to its issuer. Statistics: DATA_TABLE_RD_ARB_STATS_EN.
module data_table_rd_arbiter
  import hash_table::*;
#(
  parameter  int ENG_CNT     = 4,
  parameter  int RAM_LATENCY = 2,
  parameter  int A_WIDTH     = TABLE_ADDR_WIDTH,
  localparam int ENG_W       = $clog2(ENG_CNT)
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [ENG_CNT-1:0]              eng_rd_en_i,
  input  logic [ENG_CNT-1:0][A_WIDTH-1:0] eng_rd_addr_i,
  output logic [ENG_CNT-1:0]              eng_rd_avail_o,
  output logic [ENG_CNT-1:0]              eng_rd_data_val_o,
  output ram_data_t                       eng_rd_data_o,
  output logic [A_WIDTH-1:0]              ram_rd_addr_o,
  output logic                            ram_rd_en_o,
  input  ram_data_t                       ram_rd_data_i,
  output logic                            busy_o
`ifdef DATA_TABLE_RD_ARB_STATS_EN
  ,
  output logic [ENG_CNT-1:0][31:0]        stat_grant_cnt_o,
  output logic [31:0]                     stat_contention_cnt_o
`endif
);

  localparam logic [ENG_W-1:0] LAST_ENG = ENG_W'(ENG_CNT - 1);

  logic [ENG_CNT-1:0] w_req;
  logic [ENG_CNT-1:0] w_gnt;
  logic [ENG_W-1:0]   w_winner;
  logic               w_busy;
  logic [ENG_W-1:0]   r_rrPtr;
  rd_tag_t            r_tagPipe [RAM_LATENCY];

  // Requests are masked during reset so no grant or RAM access can leak out.
  assign w_req = rst_n_i ? eng_rd_en_i : '0;

  rr_arbiter #(
    .REQ_CNT (ENG_CNT)
  ) u_rrArbiter (
    .req     (w_req),
    .ptr     (r_rrPtr),
    .gnt     (w_gnt),
    .gnt_idx (w_winner)
  );

  assign eng_rd_avail_o = w_gnt;
  assign ram_rd_en_o    = |w_gnt;
  assign ram_rd_addr_o  = ram_rd_en_o ? eng_rd_addr_i[w_winner] : '0;
  assign eng_rd_data_o  = ram_rd_data_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rrPtr <= '0;
    end else if (ram_rd_en_o) begin
      r_rrPtr <= (w_winner == LAST_ENG) ? '0 : w_winner + 1'b1;
    end
  end

  // One tag per RAM pipeline stage; reset drops reads already in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        r_tagPipe[i] <= '0;
      end
    end else begin
      r_tagPipe[0] <= '{valid: ram_rd_en_o, engIdx: eng_idx_t'(w_winner)};
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_tagPipe[i] <= r_tagPipe[i-1];
      end
    end
  end

  always_comb begin
    eng_rd_data_val_o = '0;
    if (r_tagPipe[RAM_LATENCY-1].valid) begin
      eng_rd_data_val_o[r_tagPipe[RAM_LATENCY-1].engIdx[ENG_W-1:0]] = 1'b1;
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      w_busy = w_busy | r_tagPipe[i].valid;
    end
  end

  assign busy_o = w_busy;

`ifdef DATA_TABLE_RD_ARB_STATS_EN
  logic [ENG_CNT-1:0][31:0] r_grantCnt;
  logic [31:0]              r_contentionCnt;
  logic                     w_multiReq;

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign w_multiReq = |(eng_rd_en_i & (eng_rd_en_i - 1'b1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_grantCnt      <= '0;
      r_contentionCnt <= '0;
    end else begin
      if (ram_rd_en_o && (r_grantCnt[w_winner] != '1)) begin
        r_grantCnt[w_winner] <= r_grantCnt[w_winner] + 32'd1;
      end
      if (w_multiReq && (r_contentionCnt != '1)) begin
        r_contentionCnt <= r_contentionCnt + 32'd1;
      end
    end
  end

  assign stat_grant_cnt_o      = r_grantCnt;
  assign stat_contention_cnt_o = r_contentionCnt;
`endif

endmodule

// File: tb/tb_data_table_rd_arbiter.sv
// Self-checking bench for data_table_rd_arbiter: a 4-engine/latency-2 instance and a
// 3-engine/latency-3 instance share clock and reset and are checked against a queue model.
module tb_data_table_rd_arbiter;
  import hash_table::*;

  localparam int N_A   = 4;
  localparam int LAT_A = 2;
  localparam int N_B   = 3;
  localparam int LAT_B = 3;
  localparam int AW    = TABLE_ADDR_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  logic [N_A-1:0]         reqA;
  logic [N_A-1:0][AW-1:0] addrA;
  logic [N_A-1:0]         availA;
  logic [N_A-1:0]         valA;
  ram_data_t              engDataA;
  logic [AW-1:0]          ramAddrA;
  logic                   ramEnA;
  ram_data_t              ramDataA;
  logic                   busyA;

  logic [N_B-1:0]         reqB;
  logic [N_B-1:0][AW-1:0] addrB;
  logic [N_B-1:0]         availB;
  logic [N_B-1:0]         valB;
  ram_data_t              engDataB;
  logic [AW-1:0]          ramAddrB;
  logic                   ramEnB;
  ram_data_t              ramDataB;
  logic                   busyB;

`ifdef DATA_TABLE_RD_ARB_STATS_EN
  logic [N_A-1:0][31:0] statGrantA;
  logic [31:0]          statContA;
  logic [N_B-1:0][31:0] statGrantB;
  logic [31:0]          statContB;
`endif

  data_table_rd_arbiter #(
    .ENG_CNT     (N_A),
    .RAM_LATENCY (LAT_A),
    .A_WIDTH     (AW)
  ) dutA (
    .clk_i             (clk),
    .rst_n_i           (rstN),
    .eng_rd_en_i       (reqA),
    .eng_rd_addr_i     (addrA),
    .eng_rd_avail_o    (availA),
    .eng_rd_data_val_o (valA),
    .eng_rd_data_o     (engDataA),
    .ram_rd_addr_o     (ramAddrA),
    .ram_rd_en_o       (ramEnA),
    .ram_rd_data_i     (ramDataA),
    .busy_o            (busyA)
`ifdef DATA_TABLE_RD_ARB_STATS_EN
    ,
    .stat_grant_cnt_o      (statGrantA),
    .stat_contention_cnt_o (statContA)
`endif
  );

  data_table_rd_arbiter #(
    .ENG_CNT     (N_B),
    .RAM_LATENCY (LAT_B),
    .A_WIDTH     (AW)
  ) dutB (
    .clk_i             (clk),
    .rst_n_i           (rstN),
    .eng_rd_en_i       (reqB),
    .eng_rd_addr_i     (addrB),
    .eng_rd_avail_o    (availB),
    .eng_rd_data_val_o (valB),
    .eng_rd_data_o     (engDataB),
    .ram_rd_addr_o     (ramAddrB),
    .ram_rd_en_o       (ramEnB),
    .ram_rd_data_i     (ramDataB),
    .busy_o            (busyB)
`ifdef DATA_TABLE_RD_ARB_STATS_EN
    ,
    .stat_grant_cnt_o      (statGrantB),
    .stat_contention_cnt_o (statContB)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the round-robin pointer as an integer plus a queue of issued
  // reads stamped with their issue cycle; a read's valid is due LAT cycles later.
  typedef struct {
    int cyc;
    int eng;
  } issue_t;

  issue_t qA[$];
  issue_t qB[$];
  int     ptrA    = 0;
  int     ptrB    = 0;
  int     cycleNo = 0;
  int     gA;
  int     gB;

  typedef struct {
    logic       rstN;
    logic [3:0] req;
    logic [3:0] expAvail;
    logic       expEn;
    logic [7:0] expAddr;
    logic [3:0] expVal;
    logic       expBusy;
  } vec_t;

  vec_t tbl[$];

  function automatic int scanGrant(input int req, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (((req >> ((ptr + k) % n)) & 1) != 0) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycleNo,
               actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N_A-1:0] ra,
                               input logic [N_B-1:0] rb);
    rstN     = r;
    reqA     = ra;
    reqB     = rb;
    ramDataA = $urandom;
    ramDataB = $urandom;
  endtask

  // Called at the negedge: compares both DUTs with the model, then advances the model
  // across the next rising edge.
  task automatic modelStep();
    int expValA;
    int expValB;
    gA = rstN ? scanGrant(int'(reqA), ptrA, N_A) : -1;
    gB = rstN ? scanGrant(int'(reqB), ptrB, N_B) : -1;
    expValA = (qA.size() > 0 && qA[0].cyc == cycleNo - LAT_A) ? (1 << qA[0].eng) : 0;
    expValB = (qB.size() > 0 && qB[0].cyc == cycleNo - LAT_B) ? (1 << qB[0].eng) : 0;

    checkOutput("A.avail", availA, (gA < 0) ? 0 : (1 << gA));
    checkOutput("A.ramEn", ramEnA, (gA < 0) ? 0 : 1);
    checkOutput("A.ramAddr", ramAddrA, (gA < 0) ? 0 : addrA[gA]);
    checkOutput("A.dataVal", valA, expValA);
    checkOutput("A.busy", busyA, (qA.size() > 0) ? 1 : 0);
    checkOutput("A.data", engDataA, ramDataA);
    checkOutput("B.avail", availB, (gB < 0) ? 0 : (1 << gB));
    checkOutput("B.ramEn", ramEnB, (gB < 0) ? 0 : 1);
    checkOutput("B.ramAddr", ramAddrB, (gB < 0) ? 0 : addrB[gB]);
    checkOutput("B.dataVal", valB, expValB);
    checkOutput("B.busy", busyB, (qB.size() > 0) ? 1 : 0);
    checkOutput("B.data", engDataB, ramDataB);

    @(posedge clk);
    if (!rstN) begin
      qA.delete();
      qB.delete();
      ptrA = 0;
      ptrB = 0;
    end else begin
      if (qA.size() > 0 && qA[0].cyc == cycleNo - LAT_A) void'(qA.pop_front());
      if (qB.size() > 0 && qB[0].cyc == cycleNo - LAT_B) void'(qB.pop_front());
      if (gA >= 0) begin
        qA.push_back('{cycleNo, gA});
        ptrA = (gA + 1) % N_A;
      end
      if (gB >= 0) begin
        qB.push_back('{cycleNo, gB});
        ptrB = (gB + 1) % N_B;
      end
    end
    cycleNo++;
    #1;
  endtask

  initial begin
    // rstN, req, expAvail, expEn, expAddr, expVal, expBusy
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0});
    tbl.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1, 8'h15, 4'b0000, 1'b0});
    tbl.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1, 8'h15, 4'b0000, 1'b1});
    tbl.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1, 8'h15, 4'b0100, 1'b1});
    tbl.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1, 8'h15, 4'b0100, 1'b1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0100, 1'b1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0100, 1'b1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0});
    tbl.push_back('{1'b1, 4'b0010, 4'b0010, 1'b1, 8'h51, 4'b0000, 1'b0});
    tbl.push_back('{1'b1, 4'b1010, 4'b1000, 1'b1, 8'h73, 4'b0000, 1'b1});
    tbl.push_back('{1'b1, 4'b1010, 4'b0010, 1'b1, 8'h51, 4'b0010, 1'b1});
    tbl.push_back('{1'b1, 4'b1010, 4'b1000, 1'b1, 8'h73, 4'b1000, 1'b1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0010, 1'b1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'b1000, 1'b1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0});

    addrA = {8'h73, 8'h15, 8'h51, 8'h40};
    addrB = {8'hC2, 8'hB1, 8'hA0};
    applyStimulus(1'b0, '0, '0);

    // Directed table, starting from reset.
    foreach (tbl[v]) begin
      applyStimulus(tbl[v].rstN, tbl[v].req, '0);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d.avail", v), availA, tbl[v].expAvail);
      checkOutput($sformatf("tbl%0d.ramEn", v), ramEnA, tbl[v].expEn);
      checkOutput($sformatf("tbl%0d.ramAddr", v), ramAddrA, tbl[v].expAddr);
      checkOutput($sformatf("tbl%0d.dataVal", v), valA, tbl[v].expVal);
      checkOutput($sformatf("tbl%0d.busy", v), busyA, tbl[v].expBusy);
      modelStep();
    end

    // Full contention from a freshly reset pointer; B exercises the wrap at 3.
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);
    modelStep();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, (k < 8) ? 4'b1111 : 4'b0000, (k < 8) ? 3'b111 : 3'b000);
      @(negedge clk);
      checkOutput($sformatf("rot%0d.availA", k), availA, (k < 8) ? (1 << (k % 4)) : 0);
      checkOutput($sformatf("rot%0d.valA", k), valA,
                  (k >= 2) ? (1 << ((k - 2) % 4)) : 0);
      checkOutput($sformatf("rot%0d.availB", k), availB, (k < 8) ? (1 << (k % 3)) : 0);
      modelStep();
    end

    // Reset one cycle after a grant to engine 0: its data-valid must never appear.
    applyStimulus(1'b1, 4'b0001, '0);
    @(negedge clk);
    checkOutput("rstMid.grant", availA, 4'b0001);
    modelStep();
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);
    modelStep();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, '0, '0);
      @(negedge clk);
      checkOutput($sformatf("rstMid%0d.val0", k), valA[0], 1'b0);
      modelStep();
    end

`ifdef DATA_TABLE_RD_ARB_STATS_EN
    begin
      int sum;
      applyStimulus(1'b0, '0, '0);
      @(negedge clk);
      modelStep();
      for (int k = 0; k < 10; k++) begin
        applyStimulus(1'b1, 4'b1111, '0);
        @(negedge clk);
        modelStep();
      end
      applyStimulus(1'b1, '0, '0);
      @(negedge clk);
      sum = 0;
      for (int e = 0; e < N_A; e++) begin
        sum += int'(statGrantA[e]);
        checkOutput($sformatf("stat.grant%0dRange", e), statGrantA[e] >= 2 && statGrantA[e] <= 3, 1'b1);
      end
      checkOutput("stat.grantSum", sum, 10);
      checkOutput("stat.contention", statContA, 10);
      modelStep();
    end
`endif

    // Randomised traffic with occasional resets, checked only by the model.
    for (int k = 0; k < 400; k++) begin
      for (int e = 0; e < N_A; e++) addrA[e] = AW'($urandom);
      for (int e = 0; e < N_B; e++) addrB[e] = AW'($urandom);
      applyStimulus($urandom_range(0, 39) != 0, N_A'($urandom), N_B'($urandom));
      @(negedge clk);
      modelStep();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
